// File: rtl/peak_detector.sv
// Purpose: finds the signed maximum of each pulse that rises above THRESHOLD and timestamps it.
// Latency: the event is in the output slot one edge after the first falling sample is registered.
// Backpressure: one-entry slot holds steady until peak_ready; peaks that arrive while it is full are dropped and counted.
//
// Ports:
//   clk            - single clock, rising edge
//   reset          - asynchronous, active-low
//   input_data     - signed shaped-pulse sample, one per clk
//   peak_amplitude - signed maximum of the detected pulse (registered slot)
//   peak_time      - timestamp of the first sample that reached that maximum (raw, wraps)
//   peak_valid     - slot holds an event
//   peak_ready     - consumer takes the event on an edge where peak_valid=1
//   lost_count     - saturating count of events dropped because the slot was full
//
// HOLDOFF must lie in 1..65535 so that it fits the 16-bit hold counter.
module peak_detector #(
   parameter int SIZE_FILTER_DATA = 16,
   parameter int THRESHOLD        = 100,
   parameter int HOLDOFF          = 16,
   parameter int TS_WIDTH         = 32
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic signed [SIZE_FILTER_DATA-1:0] input_data,
   output logic signed [SIZE_FILTER_DATA-1:0] peak_amplitude,
   output logic        [TS_WIDTH-1:0]         peak_time,
   output logic                               peak_valid,
   input  logic                               peak_ready,
   output logic        [15:0]                 lost_count
);

   // Amplitude and timestamp travel together from the candidate register into the slot.
   typedef struct packed {
      logic signed [SIZE_FILTER_DATA-1:0] amp;
      logic        [TS_WIDTH-1:0]         ts;
   } peak_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RISE = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic signed [SIZE_FILTER_DATA-1:0] THR       = SIZE_FILTER_DATA'(THRESHOLD);
   localparam logic        [15:0]                 HOLD_LOAD = 16'(HOLDOFF);

   state_t                             state;
   logic signed [SIZE_FILTER_DATA-1:0] sample_q;
   logic        [TS_WIDTH-1:0]         ts_cnt;
   logic        [TS_WIDTH-1:0]         ts;
   peak_t                              cand_q;
   logic signed [SIZE_FILTER_DATA-1:0] cand_amp;
   logic        [15:0]                 hold_cnt;
   peak_t                              slot_q;
   logic                               above_thr;
   logic                               peak_fire;

   // ------------------------------------------------------------------
   // Sample register and timestamp.
   // ts_cnt runs one step ahead so that ts is always the stamp of the
   // sample currently in sample_q: the first sample registered after
   // reset release is stamped 0.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sample_q <= '0;
         ts_cnt   <= '0;
         ts       <= '0;
      end else begin
         sample_q <= input_data;
         ts       <= ts_cnt;
         ts_cnt   <= ts_cnt + TS_WIDTH'(1);
      end
   end

   assign cand_amp  = cand_q.amp;
   assign above_thr = (sample_q > THR);
   // A peak is declared on the first sample strictly below the running maximum.
   assign peak_fire = (state == RISE) && (sample_q < cand_amp);

   // ------------------------------------------------------------------
   // Detector FSM.
   // RISE tracks the running maximum; equal samples keep the earlier
   // stamp so that a flat top reports its first sample. HOLD ignores the
   // input entirely until the counter has run out AND the signal has
   // fallen back to the threshold, so a ringing tail cannot re-arm.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cand_q   <= '0;
         hold_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (above_thr) begin
                  cand_q.amp <= sample_q;
                  cand_q.ts  <= ts;
                  state      <= RISE;
               end
            end
            RISE: begin
               if (sample_q > cand_amp) begin
                  cand_q.amp <= sample_q;
                  cand_q.ts  <= ts;
               end else if (sample_q < cand_amp) begin
                  state    <= HOLD;
                  hold_cnt <= HOLD_LOAD;
               end
            end
            HOLD: begin
               if (hold_cnt != 16'd0) begin
                  hold_cnt <= hold_cnt - 16'd1;
               end else if (!above_thr) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // One-entry output slot.
   // A peak loads when the slot is empty or being emptied on this same
   // edge; otherwise it is dropped and counted. Without a new peak, a
   // transfer simply empties the slot. peak_ready has no effect while
   // the slot is empty.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slot_q     <= '0;
         peak_valid <= 1'b0;
         lost_count <= '0;
      end else begin
         if (peak_fire) begin
            if (!peak_valid || peak_ready) begin
               slot_q     <= cand_q;
               peak_valid <= 1'b1;
            end else if (lost_count != 16'hFFFF) begin
               lost_count <= lost_count + 16'd1;
            end
         end else if (peak_valid && peak_ready) begin
            peak_valid <= 1'b0;
         end
      end
   end

   assign peak_amplitude = slot_q.amp;
   assign peak_time      = slot_q.ts;

endmodule

// File: tb/tb_peak_detector.sv
module tb_peak_detector;

   localparam int DW      = 16;
   localparam int TSW     = 8;     // narrow so that random runs wrap the timestamp
   localparam int THR     = 100;
   localparam int HOLDOFF = 16;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic signed [DW-1:0] input_data = '0;
   logic signed [DW-1:0] peak_amplitude;
   logic [TSW-1:0]       peak_time;
   logic                 peak_valid;
   logic                 peak_ready = 1'b0;
   logic [15:0]          lost_count;

   int  total = 0;
   int  bad   = 0;

   // Stimulus: sample s[c] and ready r[c] are presented for edge c after release.
   int  stim_s[$];
   bit  stim_r[$];

   // Scoreboard: events in load order, plus the expected peak_valid after each edge.
   int  exp_amp[$];
   int  exp_ts[$];
   bit  vtrace[$];

   int  cur_edge   = -1;
   bit  scn_active = 1'b0;
   bit  stall_prev = 1'b0;
   int  prev_amp   = 0;
   int  prev_ts    = 0;

   peak_detector #(
      .SIZE_FILTER_DATA(DW),
      .THRESHOLD(THR),
      .HOLDOFF(HOLDOFF),
      .TS_WIDTH(TSW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .input_data(input_data),
      .peak_amplitude(peak_amplitude),
      .peak_time(peak_time),
      .peak_valid(peak_valid),
      .peak_ready(peak_ready),
      .lost_count(lost_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (edge %0d)", name, act, req, cur_edge);
      end
   endtask

   // Reference: find events from the sample stream, then play them through a one-entry slot.
   task automatic model(output int lost);
      int n;
      int fe[$];
      int fa[$];
      int ft[$];
      int i, m, mt, k, fi;
      bit v, fire;
      n    = stim_s.size();
      lost = 0;
      i    = 0;
      while (i < n) begin
         if (stim_s[i] > THR) begin
            m  = stim_s[i];
            mt = i;
            k  = i + 1;
            while (k < n && stim_s[k] >= m) begin
               if (stim_s[k] > m) begin
                  m  = stim_s[k];
                  mt = k;
               end
               k++;
            end
            if (k >= n) break;
            // Sample k is evaluated on edge k+1, where the event enters the slot.
            fe.push_back(k + 1);
            fa.push_back(m);
            ft.push_back(mt % (1 << TSW));
            // Re-arm only on a sample at least HOLDOFF+1 after k that is back at/below threshold.
            i = k + 1 + HOLDOFF;
            while (i < n && stim_s[i] > THR) i++;
            i++;
         end else begin
            i++;
         end
      end
      v  = 1'b0;
      fi = 0;
      for (int e = 0; e < n; e++) begin
         fire = (fi < fe.size()) && (fe[fi] == e);
         if (fire) begin
            if (!v || stim_r[e]) begin
               exp_amp.push_back(fa[fi]);
               exp_ts.push_back(ft[fi]);
               v = 1'b1;
            end else if (lost < 65535) begin
               lost++;
            end
            fi++;
         end else if (v && stim_r[e]) begin
            v = 1'b0;
         end
         vtrace.push_back(v);
      end
   endtask

   // Monitor: compares every transfer against the scoreboard and watches stalls.
   always @(negedge clk) begin
      if (reset && scn_active && cur_edge >= 0) begin
         if (cur_edge < vtrace.size())
            check("valid_trace", int'(peak_valid), int'(vtrace[cur_edge]));
         if (stall_prev) begin
            check("stall_amp", int'(peak_amplitude), prev_amp);
            check("stall_time", int'(peak_time), prev_ts);
         end
         if (peak_valid && peak_ready) begin
            if (exp_amp.size() == 0) begin
               check("unexpected_event", 1, 0);
            end else begin
               check("amp", int'(peak_amplitude), exp_amp.pop_front());
               check("time", int'(peak_time), exp_ts.pop_front());
            end
         end
         stall_prev = peak_valid && !peak_ready;
         prev_amp   = int'(peak_amplitude);
         prev_ts    = int'(peak_time);
      end else begin
         stall_prev = 1'b0;
      end
   end

   task automatic fill_ready(input bit r);
      while (stim_r.size() < stim_s.size()) stim_r.push_back(r);
   endtask

   task automatic add_tail();
      repeat (HOLDOFF + 8) begin
         stim_s.push_back(0);
         stim_r.push_back(1'b1);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, int'(peak_valid), 0);
      check({tag, "_amp"}, int'(peak_amplitude), 0);
      check({tag, "_time"}, int'(peak_time), 0);
      check({tag, "_lost"}, int'(lost_count), 0);
   endtask

   // Resets the DUT, runs the stored stream; abort=1 asserts reset mid-stream instead of draining.
   task automatic run_scn(input string name, input bit abort);
      int lost_exp;
      int n;
      scn_active = 1'b0;
      reset      = 1'b0;
      exp_amp.delete();
      exp_ts.delete();
      vtrace.delete();
      model(lost_exp);
      n          = stim_s.size();
      cur_edge   = -1;
      input_data = DW'(stim_s[0]);
      peak_ready = stim_r[0];
      @(negedge clk);
      #2;
      scn_active = 1'b1;
      reset      = 1'b1;
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         cur_edge = c;
         #1;
         if (c + 1 < n) begin
            input_data = DW'(stim_s[c + 1]);
            peak_ready = stim_r[c + 1];
         end else begin
            input_data = '0;
            peak_ready = 1'b1;
         end
      end
      if (abort) begin
         #2;
         scn_active = 1'b0;
         reset      = 1'b0;
         #1;
         check_reset_outputs({name, "_abort"});
         exp_amp.delete();
         exp_ts.delete();
      end else begin
         @(negedge clk);
         #1;
         scn_active = 1'b0;
         check({name, "_lost"}, int'(lost_count), lost_exp);
         check({name, "_pending"}, exp_amp.size(), 0);
      end
   endtask

   task automatic build_random(input int len);
      int nb, pk, rise, fall, flat;
      stim_s.delete();
      stim_r.delete();
      while (stim_s.size() < len) begin
         nb = $urandom_range(0, 25);
         repeat (nb) stim_s.push_back(int'($urandom_range(0, 300)) - 200);
         pk   = $urandom_range(60, 900);
         rise = $urandom_range(1, 6);
         fall = $urandom_range(1, 6);
         flat = $urandom_range(0, 3);
         for (int r = 1; r <= rise; r++) stim_s.push_back(pk * r / rise);
         repeat (flat) stim_s.push_back(pk);
         for (int f = 1; f <= fall; f++) stim_s.push_back(pk - pk * f / fall);
      end
      while (stim_r.size() < stim_s.size()) stim_r.push_back($urandom_range(0, 3) != 0);
      add_tail();
   endtask

   initial begin
      reset = 1'b0;
      #12;
      check_reset_outputs("reset");

      // Triangle: one event at 300, stamped at its index.
      stim_s = '{0, 50, 150, 300, 200, 50, 0};
      stim_r.delete(); fill_ready(1'b1); add_tail();
      run_scn("triangle", 1'b0);

      // Flat top: stamp of the first 400.
      stim_s = '{0, 200, 400, 400, 400, 100};
      stim_r.delete(); fill_ready(1'b1); add_tail();
      run_scn("flat_top", 1'b0);

      // Maximum equal to threshold: no event.
      stim_s = '{0, 50, 100, 100, 50, 0};
      stim_r.delete(); fill_ready(1'b1); add_tail();
      run_scn("at_threshold", 1'b0);

      // Consumer stalled across two pulses: first held, second dropped.
      stim_s = '{0, 150, 300, 100, 0};
      repeat (20) stim_s.push_back(0);
      stim_s.push_back(0); stim_s.push_back(200); stim_s.push_back(250); stim_s.push_back(90);
      repeat (6) stim_s.push_back(0);
      stim_r.delete(); fill_ready(1'b0); add_tail();
      run_scn("stall_drop", 1'b0);

      // Re-rise during holdoff while the signal stays above threshold.
      stim_s = '{0, 200, 400, 300};
      repeat (5) stim_s.push_back(250);
      stim_s.push_back(300); stim_s.push_back(500); stim_s.push_back(700);
      repeat (20) stim_s.push_back(600);
      stim_s.push_back(50); stim_s.push_back(0); stim_s.push_back(0);
      stim_s.push_back(0); stim_s.push_back(300); stim_s.push_back(150); stim_s.push_back(0);
      stim_r.delete(); fill_ready(1'b1); add_tail();
      run_scn("holdoff", 1'b0);

      // Held event, then reset during the next rise: everything cleared at once.
      stim_s = '{0, 150, 300, 100, 0};
      repeat (20) stim_s.push_back(0);
      stim_s.push_back(0); stim_s.push_back(200); stim_s.push_back(400); stim_s.push_back(500);
      stim_r.delete(); fill_ready(1'b0);
      run_scn("reset_rise", 1'b1);

      // Same triangle after that reset: timestamp restarts at 0.
      stim_s = '{0, 50, 150, 300, 200, 50, 0};
      stim_r.delete(); fill_ready(1'b1); add_tail();
      run_scn("after_reset", 1'b0);

      for (int k = 0; k < 3; k++) begin
         build_random(600);
         run_scn("random", 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
